// File: rtl/sccb_target.sv
// SCCB responder modelling a camera target: 256 x 8 register file with sensor-like
// defaults, 3-phase write and 2-phase read decode, open-drain SIOD drive.
// Optional build macro: SCCB_TARGET_ACK_EN drives SIOD low during every accepted 9th bit.
module sccb_target #(
   parameter logic [6:0] DEV_ID      = 7'h21,
   parameter logic [7:0] PID_DEFAULT = 8'h76,
   parameter logic [7:0] VER_DEFAULT = 8'h73
) (
   input  logic       PCLK,
   input  logic       PRESETN,
   input  logic       sioc,
   input  logic       siod_i,
   output logic       siod_oe,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

`ifdef SCCB_TARGET_ACK_EN
   localparam logic AckDrive = 1'b1;
`else
   localparam logic AckDrive = 1'b0;
`endif

   localparam logic [7:0] SoftRstAddr = 8'h12;

   typedef enum logic [3:0] {
      StIdle, StId, StIdAck, StSub, StSubAck, StWdata, StWdataAck, StRdata, StRna, StIgnore
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  sioc_s_q, siod_s_q;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  sub_ptr_q, sub_ptr_d;
   logic        rw_q, rw_d;
   logic        siod_oe_q, siod_oe_d;
   logic        busy_q, busy_d;
   logic        wr_valid_q, wr_valid_d;
   logic [7:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        soft_rst_q, soft_rst_d;
   logic        reg_we;
   logic [7:0]  regs_q [256];

   logic        scl, scl_prev, sda, sda_prev;
   logic        rise, fall, start_ev, stop_ev;
   logic [7:0]  byte_in;
   logic [7:0]  rd_byte;

   function automatic logic [7:0] reg_default(input int unsigned a);
      if (a == 32'h0A) return PID_DEFAULT;
      if (a == 32'h0B) return VER_DEFAULT;
      return 8'h00;
   endfunction

   // Two-flop synchronizers plus a third stage for edge detection; idle bus is high.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         sioc_s_q <= 3'b111;
         siod_s_q <= 3'b111;
      end else begin
         sioc_s_q <= {sioc_s_q[1:0], sioc};
         siod_s_q <= {siod_s_q[1:0], siod_i};
      end
   end

   // Line events; START/STOP need SIOC stable high so a same-cycle change is an SIOC edge only.
   always_comb begin
      scl      = sioc_s_q[1];
      scl_prev = sioc_s_q[2];
      sda      = siod_s_q[1];
      sda_prev = siod_s_q[2];
      rise     = scl & ~scl_prev;
      fall     = ~scl & scl_prev;
      start_ev = scl & scl_prev & sda_prev & ~sda;
      stop_ev  = scl & scl_prev & ~sda_prev & sda;
      byte_in  = {shift_q[6:0], sda};
      rd_byte  = regs_q[sub_ptr_q];
   end

   // Protocol FSM next-state; ACK states use cnt 8 -> 9 on the first fall, leave on the second.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      sub_ptr_d  = sub_ptr_q;
      rw_d       = rw_q;
      siod_oe_d  = siod_oe_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      soft_rst_d = 1'b0;
      reg_we     = 1'b0;
      if (stop_ev) begin
         state_d   = StIdle;
         cnt_d     = 4'd0;
         siod_oe_d = 1'b0;
         busy_d    = 1'b0;
      end else if (start_ev) begin
         state_d   = StId;
         cnt_d     = 4'd0;
         siod_oe_d = 1'b0;
         busy_d    = 1'b1;
      end else begin
         case (state_q)
            StId: begin
               if (rise) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     if (byte_in[7:1] == DEV_ID) begin
                        state_d = StIdAck;
                        rw_d    = byte_in[0];
                     end else begin
                        state_d = StIgnore;
                     end
                  end
               end
            end
            StSub: begin
               if (rise) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     sub_ptr_d = byte_in;
                     state_d   = StSubAck;
                  end
               end
            end
            StWdata: begin
               if (rise) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     reg_we     = 1'b1;
                     wr_valid_d = 1'b1;
                     wr_addr_d  = sub_ptr_q;
                     wr_data_d  = byte_in;
                     soft_rst_d = (sub_ptr_q == SoftRstAddr) && byte_in[7];
                     state_d    = StWdataAck;
                  end
               end
            end
            StIdAck, StSubAck, StWdataAck: begin
               if (fall) begin
                  if (cnt_q == 4'd8) begin
                     cnt_d     = 4'd9;
                     siod_oe_d = AckDrive;
                  end else begin
                     cnt_d     = 4'd0;
                     siod_oe_d = 1'b0;
                     if (state_q == StIdAck) begin
                        if (rw_q) begin
                           state_d   = StRdata;
                           shift_d   = rd_byte;
                           siod_oe_d = ~rd_byte[7];
                        end else begin
                           state_d = StSub;
                        end
                     end else if (state_q == StSubAck) begin
                        state_d = StWdata;
                     end else begin
                        state_d = StIgnore;
                     end
                  end
               end
            end
            StRdata: begin
               if (rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (fall) begin
                  if (cnt_q == 4'd8) begin
                     siod_oe_d = 1'b0;
                     state_d   = StRna;
                  end else begin
                     shift_d   = {shift_q[6:0], 1'b0};
                     siod_oe_d = ~shift_q[6];
                  end
               end
            end
            StRna: begin
               if (rise) state_d = StIgnore;
            end
            StIdle, StIgnore: ;
            default: begin
               state_d   = StIdle;
               siod_oe_d = 1'b0;
            end
         endcase
      end
   end

   // Control and output registers.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         shift_q    <= 8'h00;
         sub_ptr_q  <= 8'h00;
         rw_q       <= 1'b0;
         siod_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 8'h00;
         wr_data_q  <= 8'h00;
         soft_rst_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         sub_ptr_q  <= sub_ptr_d;
         rw_q       <= rw_d;
         siod_oe_q  <= siod_oe_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         soft_rst_q <= soft_rst_d;
      end
   end

   // Register file; soft reset lands the cycle after the committing write.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         for (int i = 0; i < 256; i++) regs_q[i] <= reg_default(i);
      end else if (soft_rst_q) begin
         for (int i = 0; i < 256; i++) regs_q[i] <= reg_default(i);
      end else if (reg_we) begin
         regs_q[sub_ptr_q] <= byte_in;
      end
   end

   assign siod_oe  = siod_oe_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = busy_q;

endmodule

// File: doc/sccb_target.md
# sccb_target

Synthesizable SCCB responder modelling the camera side of the SCCB link driven by the FPGA's SCCB initiator. It samples `sioc`/`siod` on `PCLK` and decodes 3-phase writes and 2-phase write + 2-phase read transactions. It holds a 256 x 8 register file with camera-like defaults and drives `siod` open-drain for ACK and read data. It serves as the loop-back target for initiator bring-up in simulation and on the FPGA, in place of a real sensor.

## Interface
- `DEV_ID`, 7'h21: 7-bit device address; 8-bit form is 0x42 for write, 0x43 for read.
- `PID_DEFAULT`, 8'h76: reset value of register 0x0A.
- `VER_DEFAULT`, 8'h73: reset value of register 0x0B.
- `PCLK` input 1: system clock; all logic on rising edge.
- `PRESETN` input 1: asynchronous active-low reset.
- `sioc` input 1: SCCB clock from the initiator; asynchronous to `PCLK`.
- `siod_i` input 1: sampled SIOD line; asynchronous.
- `siod_oe` output 1: 1 = pull SIOD low; 0 = release. The pad is open-drain, driving 0 when `siod_oe` is 1, else Z.
- `wr_valid` output 1: one-cycle pulse when a phase-3 data byte is committed.
- `wr_addr` output 8: sub-address of the last committed write.
- `wr_data` output 8: data of the last committed write.
- `busy` output 1: 1 from START detect to STOP detect.

## Operation
- **Input conditioning**: 2-flop synchronizers on `sioc` and `siod_i`, then a third register for edge detect.
- **Line events**:
  - START = SIOD fall while SIOC high.
  - STOP = SIOD rise while SIOC high.
  - `rise`/`fall` = SIOC edges.
- **Bit timing**: bits are sampled on SIOC rise, MSB first. The target changes `siod_oe` only on SIOC fall.
- **States**: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RNA, IGNORE.
- **IDLE**: START -> ID, bit counter = 0.
- **ID**: after 8 bits, compare the upper 7 bits with `DEV_ID`.
  - Mismatch -> IGNORE.
  - Match -> ID_ACK, latching the R/W bit.
- **ID_ACK**: on the SIOC fall following bit 8, drive the ACK. On the next SIOC fall, release the line.
  - R/W = 0 -> SUB.
  - R/W = 1 -> RDATA, loading the shift register with `regs[sub_ptr]`.
- **SUB**: 8 bits -> `sub_ptr`, then SUB_ACK -> WDATA.
- **WDATA**: 8 bits, then WDATA_ACK.
  - Commit `regs[sub_ptr]`.
  - Pulse `wr_valid`, update `wr_addr`/`wr_data`.
  - Next state is IGNORE. Extra bytes are not written, and there is no auto-increment.
- **RDATA**:
  - Drive `siod_oe = ~shift[7]` on each SIOC fall, 8 bits total.
  - Release on the fall after bit 8, then go to RNA.
  - RNA samples the master's NA/ACK on the 9th rise (value ignored), then goes to IGNORE.
- **IGNORE**: waits for STOP or START; the line is released.
- **STOP in any state**: -> IDLE, `siod_oe` = 0 on the same cycle.
  - Partial bytes are discarded.
  - `sub_ptr` is retained, so a 2-phase write followed by STOP and a 2-phase read returns `regs[sub_ptr]`.
- **START in any non-IDLE state** (repeated start): -> ID, counter cleared, line released.
- **Soft reset**: a committed write of a value with bit 7 set to address 0x12 restores all registers to defaults on the next cycle.
  - Register 0x12 itself reads 0x00 afterwards, so bit 7 is self-clearing.
  - `wr_valid` still pulses.
- **Register defaults**: all 0x00, except 0x0A = `PID_DEFAULT` and 0x0B = `VER_DEFAULT`.
- **Reset values**:
  - `siod_oe`=0, `wr_valid`=0, `wr_addr`=0x00, `wr_data`=0x00, `busy`=0.
  - `sub_ptr`=0x00, state IDLE, register file at defaults.
- **Reset mid-transaction**: asynchronous. SIOD is released immediately and any in-flight byte is lost.

## Timing
- Event latency: 3 `PCLK` cycles from a pin edge to the internal event, plus 1 cycle to `siod_oe`.
- Requirement: `PCLK` >= 16 x SIOC frequency (50 MHz vs 100 kHz gives ample margin). The bit is stable on the line for at least 1 synchronizer delay before SIOC rises.
- `wr_valid`: asserted 1 cycle after the SIOC rise event of data bit 8 (bit 0).
- `busy`: rises 1 cycle after the START event and falls 1 cycle after the STOP event.
- Simultaneous SIOC and SIOD change in the same sampled cycle: treated as an SIOC edge only; no START/STOP is recognised.

## Configuration
- `SCCB_TARGET_ACK_EN`
  - **Defined**: the target drives SIOD low during the 9th bit of every phase it accepts (ID match, sub-address, write data).
  - **Undefined**: the 9th bit is pure SCCB "don't care". The target releases SIOD during every 9th bit; state sequencing is otherwise identical.

## Test plan
- **Write**: 0x42, 0x12, 0x05 then STOP -> `wr_valid` pulse with `wr_addr`=0x12, `wr_data`=0x05. A later read of 0x12 returns 0x05. With the macro defined, `siod_oe`=1 during three 9th bits.
- **Read defaults**:
  - 0x42, 0x0A, STOP, then 0x43 -> target shifts 0x76.
  - Repeating with 0x0B returns 0x73.
  - `siod_oe` is only asserted for the 0 bits of the data.
- **Soft reset**: write 0x42 to 0x03, write 0x80 to 0x12 -> a read of 0x03 returns 0x00 and a read of 0x12 returns 0x00.
- **ID mismatch**: 0x60, 0x12, 0x55 -> no ACK, no `wr_valid`, register 0x12 unchanged, `busy` falls at STOP.
- **STOP after 4 data bits**: no commit, state IDLE. A following valid write to 0x20 = 0xA5 commits correctly.
- **Async reset**: assert `PRESETN` low during RDATA with `siod_oe`=1 -> `siod_oe`=0 without waiting for a clock edge, and all outputs at reset values.
